// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions for the VGA timing generator.
// Holds the default 640x480@60 constants, their derived totals, the
// per-axis phase encoding and a helper that maps a phase to a sync level.
package vga_timing_pkg;

    localparam int unsigned POS_W = 10;
    localparam int unsigned FC_W  = 8;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;

    localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Phase of one raster axis, in scan order.
    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_e;

    // Sync pin level for a given phase: active level only inside the pulse.
    function automatic logic sync_level(input phase_e ph, input logic active);
        return (ph == PH_SYNC) ? active : ~active;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus phase FSM (ACT -> FP -> SYNC -> BP).
// Ports:
//   clk, rst_n  - clock, async active-low reset (resets to the last position)
//   inc         - advance one position this cycle
//   force_last  - jump to the last position (overrides inc)
//   pos         - current position, registered
//   phase_c     - phase that will hold after this edge (next-state view)
//   wrap_c      - this cycle's advance wraps TOTAL-1 -> 0
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FRONT  = DEF_H_FRONT,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BACK   = DEF_H_BACK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             force_last,
    output logic [POS_W-1:0] pos,
    output phase_e           phase_c,
    output logic             wrap_c
);

    localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC + BACK;

    // Last position of each phase; the phase changes on the advance after it.
    localparam logic [POS_W-1:0] END_ACT  = POS_W'(ACTIVE - 1);
    localparam logic [POS_W-1:0] END_FP   = POS_W'(ACTIVE + FRONT - 1);
    localparam logic [POS_W-1:0] END_SYNC = POS_W'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [POS_W-1:0] LAST     = POS_W'(TOTAL - 1);

    logic [POS_W-1:0] pos_q, pos_d;
    phase_e           phase_q, phase_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q   <= LAST;
            phase_q <= PH_BP;
        end else begin
            pos_q   <= pos_d;
            phase_q <= phase_d;
        end
    end

    // Next position and phase
    always_comb begin
        pos_d   = pos_q;
        phase_d = phase_q;
        wrap_c  = 1'b0;
        if (force_last) begin
            pos_d   = LAST;
            phase_d = PH_BP;
        end else if (inc) begin
            if (pos_q == LAST) begin
                pos_d  = '0;
                wrap_c = 1'b1;
            end else begin
                pos_d = pos_q + POS_W'(1);
            end
            case (phase_q)
                PH_ACT:  if (pos_q == END_ACT)  phase_d = PH_FP;
                PH_FP:   if (pos_q == END_FP)   phase_d = PH_SYNC;
                PH_SYNC: if (pos_q == END_SYNC) phase_d = PH_BP;
                PH_BP:   if (pos_q == LAST)     phase_d = PH_ACT;
                default: phase_d = PH_BP;
            endcase
        end
    end

    assign pos     = pos_q;
    assign phase_c = phase_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: hsync/vsync, active-video flag, pixel
// coordinates, line/frame start strobes and a wrapping frame counter.
// All outputs are registered; sync and display_on are derived from the
// next-state phases so they line up with hpos/vpos in the same cycle.
// Optional build macro VGA_TIMING_RESYNC_EN adds a 'resync' input that
// jumps back to the reset position on the next edge (frame_count kept).
// Ports:
//   clk, rst_n   - pixel clock, async active-low reset
//   ena          - pixel tick; state advances only when high
//   resync       - (VGA_TIMING_RESYNC_EN only) return to reset position
//   hpos, vpos   - current column / line
//   hsync, vsync - sync outputs, polarity set by SYNC_ACTIVE
//   display_on   - inside the visible area
//   line_start   - one-cycle pulse when hpos becomes 0
//   frame_start  - one-cycle pulse when (hpos,vpos) becomes (0,0)
//   frame_count  - frames started since reset, wraps at 255
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT     = DEF_H_FRONT,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BACK      = DEF_H_BACK,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT     = DEF_V_FRONT,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
`ifdef VGA_TIMING_RESYNC_EN
    input  logic             resync,
`endif
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_count
);

    logic   resync_c;
    logic   h_wrap_c, v_wrap_c, v_inc_c;
    phase_e h_phase_c, v_phase_c;

`ifdef VGA_TIMING_RESYNC_EN
    assign resync_c = resync;
`else
    assign resync_c = 1'b0;
`endif

    // Vertical axis steps only on the tick that wraps the line.
    assign v_inc_c = ena & h_wrap_c;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (ena),
        .force_last (resync_c),
        .pos        (hpos),
        .phase_c    (h_phase_c),
        .wrap_c     (h_wrap_c)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (v_inc_c),
        .force_last (resync_c),
        .pos        (vpos),
        .phase_c    (v_phase_c),
        .wrap_c     (v_wrap_c)
    );

    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            display_on_q, display_on_d;
    logic            line_start_q, line_start_d;
    logic            frame_start_q, frame_start_d;
    logic [FC_W-1:0] frame_count_q, frame_count_d;

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            display_on_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Next output values; wraps are already gated by ena and suppressed by resync.
    always_comb begin
        hsync_d       = sync_level(h_phase_c, SYNC_ACTIVE);
        vsync_d       = sync_level(v_phase_c, SYNC_ACTIVE);
        display_on_d  = (h_phase_c == PH_ACT) && (v_phase_c == PH_ACT);
        line_start_d  = h_wrap_c;
        frame_start_d = h_wrap_c & v_wrap_c;
        frame_count_d = frame_count_q + FC_W'(frame_start_d);
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule
